// File: rtl/demux_route_4.sv
// Purpose: registered 1-to-4 demux, one word stream steered by in_sel into four holding registers.
// Latency: 1 cycle from input acceptance to out_valid/out_data on the selected channel.
// Backpressure: in_ready drops only when the addressed channel is full and its consumer is stalled.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   producer handshake; in_data and in_sel qualified by in_valid
//   out_valid/out_ready per-channel consumer handshake (bit i = channel i)
//   out_data            channel i word at [i*WIDTH +: WIDTH]
//   accept_count        wrapping count of accepted input words
module demux_route_4 #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [15:0]        accept_count
);

  logic [3:0]       valid_q, valid_d;
  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [15:0]      count_q, count_d;
  logic             in_fire;

  // Only the addressed channel can stall the producer; a full channel whose
  // consumer is draining this cycle still accepts (drain and fill together).
  always_comb begin
    in_ready = !valid_q[in_sel] | out_ready[in_sel];
    in_fire  = in_valid & in_ready;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      data_d[i]  = data_q[i];
      valid_d[i] = valid_q[i] & ~out_ready[i];
      // A fill overrides a same-cycle drain so the channel never bubbles.
      if (in_fire && (in_sel == 2'(i))) begin
        valid_d[i] = 1'b1;
        data_d[i]  = in_data;
      end
    end
    count_d = count_q + 16'(in_fire);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 4'b0000;
      count_q <= 16'h0000;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign out_data[g*WIDTH +: WIDTH] = data_q[g];
  end

  assign out_valid    = valid_q;
  assign accept_count = count_q;

endmodule

// File: tb/tb_demux_route_4.sv
module tb_demux_route_4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic [1:0]   in_sel;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [127:0] out_data;
  logic [15:0]  accept_count;

  int n_cmp = 0;
  int n_bad = 0;

  demux_route_4 #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_sel       (in_sel),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .accept_count (accept_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ch(input int i);
    return out_data[i*32 +: 32];
  endfunction

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] words1 [4];
  logic [1:0]  sels5 [7];

  initial begin
    words1 = '{32'hA0, 32'hB1, 32'hC2, 32'hD3};
    sels5  = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd0, 2'd3};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    out_ready = 4'b0000;
    step();
    step();
    chk("rst_valid", 64'(out_valid), 64'h0);
    for (int i = 0; i < 4; i++) chk($sformatf("rst_data%0d", i), 64'(ch(i)), 64'h0);
    chk("rst_count", 64'(accept_count), 64'h0);
    reset = 1'b0;

    // 1: basic routing, consumers stalled
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_sel   = 2'(k);
      in_data  = words1[k];
      step();
    end
    in_valid = 1'b0;
    chk("route_valid", 64'(out_valid), 64'hF);
    for (int i = 0; i < 4; i++) chk($sformatf("route_data%0d", i), 64'(ch(i)), 64'(words1[i]));
    chk("route_count", 64'(accept_count), 64'd4);

    // empty channel 0 so it can take a redirected word
    out_ready = 4'b0001;
    step();
    out_ready = 4'b0000;
    chk("drain0_valid", 64'(out_valid), 64'hE);

    // 2: per-channel backpressure
    in_valid = 1'b1;
    in_sel   = 2'd2;
    in_data  = 32'h55;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_ready", 64'(in_ready), 64'h0);
      step();
      chk("bp_hold2", 64'(ch(2)), 64'hC2);
    end
    in_sel = 2'd0;
    #1;
    chk("redir_ready", 64'(in_ready), 64'h1);
    step();
    in_valid = 1'b0;
    chk("redir_data0", 64'(ch(0)), 64'h55);
    chk("redir_valid", 64'(out_valid), 64'hF);
    chk("redir_count", 64'(accept_count), 64'd5);

    // 3: same-cycle drain and fill on channel 1
    out_ready = 4'b0010;
    in_valid  = 1'b1;
    in_sel    = 2'd1;
    in_data   = 32'h11;
    step();
    chk("df_pre_data1", 64'(ch(1)), 64'h11);
    in_data = 32'h22;
    #1;
    chk("df_ready", 64'(in_ready), 64'h1);
    step();
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    chk("df_valid", 64'(out_valid), 64'hF);
    chk("df_data1", 64'(ch(1)), 64'h22);
    chk("df_count", 64'(accept_count), 64'd7);

    // 4: concurrent drains on channels 1 and 3
    out_ready = 4'b1010;
    step();
    out_ready = 4'b0000;
    chk("cd_valid", 64'(out_valid), 64'h5);
    chk("cd_data0", 64'(ch(0)), 64'h55);
    chk("cd_data2", 64'(ch(2)), 64'hC2);

    // 5: reset mid-operation; rebuild channels 0/3 full with count 7
    reset = 1'b1;
    step();
    reset     = 1'b0;
    out_ready = 4'b0110;
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1;
      in_sel   = sels5[k];
      in_data  = 32'h100 + 32'(k);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    step();
    chk("pre_rst_valid", 64'(out_valid), 64'h9);
    chk("pre_rst_count", 64'(accept_count), 64'd7);
    chk("pre_rst_data3", 64'(ch(3)), 64'h106);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_sel   = 2'd1;
    in_data  = 32'h99;
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("mid_rst_valid", 64'(out_valid), 64'h0);
    chk("mid_rst_count", 64'(accept_count), 64'h0);
    chk("mid_rst_data1", 64'(ch(1)), 64'h0);
    chk("mid_rst_data0", 64'(ch(0)), 64'h0);

    // 6: counter wrap with sustained throughput
    out_ready = 4'b1111;
    for (int k = 1; k <= 65537; k++) begin
      in_valid = 1'b1;
      in_sel   = 2'(k % 4);
      in_data  = 32'(k);
      step();
      chk("wrap_valid", 64'(out_valid), 64'(4'b0001 << (k % 4)));
      chk("wrap_data", 64'(ch(k % 4)), 64'(k));
      if (k == 65535) chk("cnt_ffff", 64'(accept_count), 64'hFFFF);
      if (k == 65536) chk("cnt_wrap0", 64'(accept_count), 64'h0);
      if (k == 65537) chk("cnt_wrap1", 64'(accept_count), 64'h1);
    end
    in_valid = 1'b0;
    step();
    chk("end_valid", 64'(out_valid), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demux_route_4.md
# demux_route_4

Registered 1-to-4 demultiplexer with valid/ready handshakes. Inverse of the datapath 2:1/4:1 select muxes: one input word stream is steered by a 2-bit select to one of four output channels. Each channel has a one-entry holding register, so a stalled consumer blocks only its own channel. It sits between a single producer, such as the ALU/result bus, and up to four independent consumers, such as writeback targets.

## Interface
Parameters:
- WIDTH, 32, data word width in bits

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  producer has a word on in_data
- in_ready  out  1  block accepts the word this cycle
- in_data  in  WIDTH  input word
- in_sel  in  2  destination channel, 0..3; sampled with in_data
- out_valid  out  4  bit i: channel i holding register is full
- out_ready  in  4  bit i: consumer i takes the word this cycle
- out_data  out  4*WIDTH  channel i word at [i*WIDTH +: WIDTH]
- accept_count  out  16  number of input words accepted, wrapping

## Operation
- Input transfer: in_valid & in_ready on a rising clk edge.
- Output transfer on channel i: out_valid[i] & out_ready[i] on a rising clk edge.
- in_ready is combinational: `!out_valid[in_sel] | out_ready[in_sel]`.
  - It depends only on the addressed channel.
  - Other channels' state never stalls the input.
- On input transfer to channel s:
  - out_data[s] <= in_data.
  - out_valid[s] <= 1.
- On output transfer on channel i with no input transfer to i: out_valid[i] <= 0.
- Same-cycle drain and fill of channel s:
  - out_data[s] takes the new word.
  - out_valid[s] stays 1.
  - No bubble.
- Channels are fully independent.
  - Any combination of drains across the four channels in one cycle is legal.
  - At most one fill per cycle.
- out_data[i] holds its last value while out_valid[i]=0. Consumers must ignore it when not valid.
- accept_count increments by 1 per input transfer and wraps from 16'hFFFF to 16'h0000.
- in_valid=0: in_sel and in_data are don't-care, and no state changes except drains.
- in_data and in_sel must stay stable while in_valid=1 and in_ready=0. This is a producer obligation; the block does not check it.

## Timing
- Latency: a word accepted at edge N is visible on out_data/out_valid immediately after edge N, i.e. 1 cycle.
- Throughput: 1 word/cycle sustained, when consumers hold out_ready=1 or words rotate across channels.
- Reset is synchronous; at any edge with reset=1:
  - out_valid=4'b0000, out_data all 0, accept_count=0.
  - Pending words are discarded, including a reset mid-stream with channels full.
  - A simultaneous input transfer is ignored. in_ready may be 1 during reset, but the edge has no effect.
- First accept is possible at the first edge after reset deasserts.
- in_ready has a combinational path from in_sel and out_ready. Nothing else is combinational to outputs.

## Test plan
1. Reset and basic routing:
   - Stimulus: assert reset 2 cycles, then send 32'hA0 sel 0, 32'hB1 sel 1, 32'hC2 sel 2, 32'hD3 sel 3 on consecutive cycles, out_ready=4'b0000.
   - Required: after reset, out_valid=0, out_data=0, accept_count=0. After the sends, out_valid=4'b1111, each channel holds its word, accept_count=4.
2. Backpressure per channel:
   - Stimulus: channel 2 full with out_ready[2]=0, then present 32'h55 sel 2.
   - Required: in_ready=0 for several cycles, out_data[2] unchanged. Switch to sel 0 (empty): in_ready=1 the same cycle and 32'h55 lands in channel 0.
3. Same-cycle drain and fill:
   - Stimulus: channel 1 holds 32'h11, out_ready[1]=1, present 32'h22 sel 1.
   - Required: in_ready=1. After the edge, out_valid[1]=1 and out_data[1]=32'h22, with no empty cycle.
4. Concurrent drains:
   - Stimulus: all four channels full, out_ready=4'b1010, no input.
   - Required: after one edge, out_valid=4'b0101 and channels 0 and 2 are unchanged.
5. Reset mid-operation:
   - Stimulus: channels 0 and 3 full, accept_count=7, reset asserted together with in_valid=1 sel 1.
   - Required: after the edge, out_valid=0, accept_count=0, and channel 1 is not loaded.
6. Counter wrap:
   - Stimulus: 65537 accepted words, out_ready=4'b1111, sel cycling 0..3.
   - Required: accept_count reads 16'hFFFF after word 65535, 0 after 65536, and 1 after 65537. Every word appears on its selected channel exactly one cycle after acceptance.
